// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, step size, terminal-count flags and wrap pulse.
// Build option: define UDC_SATURATE_EN to clamp at the endpoints instead of wrapping.
module updown_counter_mod #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int unsigned      STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              wrap
);

  localparam int unsigned   CW   = WIDTH + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_VAL);
  localparam logic [CW-1:0] MOD  = MAXC + CW'(1);

  logic [CW-1:0]    cur_c;
  logic [CW-1:0]    step_c;
  logic [CW-1:0]    sum_c;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;

  // Next count: load beats count beats hold; arithmetic is one bit wider than the count
  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    cur_c    = CW'(out);
    step_c   = CW'(step) % MOD;
    sum_c    = cur_c + step_c;
    if (load) begin
      out_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en && (step != '0)) begin
      if (up_down) begin
        if (sum_c > MAXC) begin
          wrap_nxt = 1'b1;
`ifdef UDC_SATURATE_EN
          out_nxt  = MAX_VAL;
`else
          out_nxt  = WIDTH'(sum_c - MOD);
`endif
        end else begin
          out_nxt = WIDTH'(sum_c);
        end
      end else begin
        if (step_c > cur_c) begin
          wrap_nxt = 1'b1;
`ifdef UDC_SATURATE_EN
          out_nxt  = '0;
`else
          out_nxt  = WIDTH'(cur_c + MOD - step_c);
`endif
        end else begin
          out_nxt = WIDTH'(cur_c - step_c);
        end
      end
    end
  end

  // Flags are registered from the next value so they always track out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      wrap  <= 1'b0;
      tc_up <= 1'b0;
      tc_dn <= 1'b1;
    end else begin
      out   <= out_nxt;
      wrap  <= wrap_nxt;
      tc_up <= (out_nxt == MAX_VAL);
      tc_dn <= (out_nxt == '0);
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: three instances (MAX_VAL 9, 255, 99) share stimulus;
// a scoreboard queue feeds a per-cycle monitor, plus directed checks at key points.
module tb_updown_counter_mod;

`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] o;
    logic       tu;
    logic       td;
    logic       w;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_down;
  logic [3:0] step;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] o  [3];
  logic       tu [3];
  logic       td [3];
  logic       w  [3];

  int   mx  [3] = '{9, 255, 99};
  int   cur [3];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  updown_counter_mod #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4)) u_m9 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .out(o[0]), .tc_up(tu[0]), .tc_dn(td[0]), .wrap(w[0]));
  updown_counter_mod #(.WIDTH(8), .STEP_W(4)) u_m255 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .out(o[1]), .tc_up(tu[1]), .tc_dn(td[1]), .wrap(w[1]));
  updown_counter_mod #(.WIDTH(8), .MAX_VAL(8'd99), .STEP_W(4)) u_m99 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .out(o[2]), .tc_up(tu[2]), .tc_dn(td[2]), .wrap(w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour written with plain integer arithmetic
  function automatic exp_t model(input int c, input int m, input bit l, input int lv,
                                 input bit e, input bit ud, input int st);
    exp_t r;
    int   v;
    int   s;
    int   nx;
    bit   wr;
    nx = c;
    wr = 1'b0;
    if (l) begin
      nx = (lv > m) ? m : lv;
    end else if (e && st != 0) begin
      s = st % (m + 1);
      v = ud ? c + s : c - s;
      if (v > m || v < 0) begin
        wr = 1'b1;
        if (SAT) nx = (v > m) ? m : 0;
        else     nx = (v + m + 1) % (m + 1);
      end else begin
        nx = v;
      end
    end
    r.o  = 8'(nx);
    r.tu = (nx == m);
    r.td = (nx == 0);
    r.w  = wr;
    return r;
  endfunction

  // One clock of stimulus; expected results are queued for the monitor
  task automatic cyc(input bit l, input int lv, input bit e, input bit ud, input int st);
    exp_t x;
    @(negedge clk);
    load     = l;
    load_val = 8'(lv);
    en       = e;
    up_down  = ud;
    step     = 4'(st);
    for (int i = 0; i < 3; i++) begin
      x      = model(cur[i], mx[i], l, lv, e, ud, st);
      cur[i] = int'(x.o);
      sb_q.push_back(x);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_out"}, int'(o[i]), 0);
      chk({tag, "_tc_dn"}, int'(td[i]), 1);
      chk({tag, "_tc_up"}, int'(tu[i]), 0);
      chk({tag, "_wrap"}, int'(w[i]), 0);
    end
  endtask

  // Monitor: every cycle the DUTs present a result, compare against the queued model
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() >= 3) begin
        for (int i = 0; i < 3; i++) begin
          x = sb_q.pop_front();
          if ({o[i], tu[i], td[i], w[i]} != x) begin
            n_fail++;
            $display("FAIL sb_inst%0d: got out=%0d tc_up=%0b tc_dn=%0b wrap=%0b, expected out=%0d tc_up=%0b tc_dn=%0b wrap=%0b",
                     i, o[i], tu[i], td[i], w[i], x.o, x.tu, x.td, x.w);
          end
          n_checks++;
        end
      end
    end
  end

  initial begin
    int wraps;
    rst = 1'b1; en = 1'b0; up_down = 1'b0; step = '0; load = 1'b0; load_val = '0;
    for (int i = 0; i < 3; i++) cur[i] = 0;
    #1 rst = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset("por_hold");

    // Wrap up: MAX 9, from 8 by 3
    cyc(1, 8, 0, 0, 0);
    cyc(0, 0, 1, 1, 3);
    settle();
    chk("wrap_up_out", int'(o[0]), SAT ? 9 : 1);
    chk("wrap_up_pulse", int'(w[0]), 1);
    cyc(0, 0, 0, 1, 3);
    settle();
    chk("wrap_up_pulse_end", int'(w[0]), 0);

    // Wrap down: MAX 255, from 2 by 5
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 5);
    settle();
    chk("wrap_dn_out", int'(o[1]), SAT ? 0 : 253);
    chk("wrap_dn_pulse", int'(w[1]), 1);

    // Load wins over count; out-of-range load clamps
    cyc(1, 8'h40, 1, 1, 1);
    settle();
    chk("prio_out", int'(o[1]), 8'h40);
    chk("prio_wrap", int'(w[1]), 0);
    cyc(1, 8'hFF, 1, 1, 1);
    settle();
    chk("clamp_out", int'(o[2]), 99);
    chk("clamp_tc_up", int'(tu[2]), 1);

    // Hold with step 0, then with en low
    cyc(1, 5, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 0);
    settle();
    chk("hold_step0_out", int'(o[1]), 5);
    chk("hold_step0_wrap", int'(w[1]), 0);
    cyc(0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 7);
    settle();
    chk("hold_en0_out", int'(o[1]), 5);

    // Step above the modulus is reduced: MAX 9, step 15 acts as 5
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 15);
    settle();
    chk("step_mod_out", int'(o[0]), 5);
    chk("step_mod_wrap", int'(w[0]), 0);

    // Asynchronous reset mid-count at 0x37
    cyc(1, 8'h30, 0, 0, 0);
    cyc(0, 0, 1, 1, 7);
    settle();
    chk("pre_reset_out", int'(o[1]), 8'h37);
    en = 1'b0; load = 1'b0; step = '0;
    rst = 1'b0;
    #1 chk_reset("async_rst");
    @(posedge clk);
    #1 chk_reset("rst_held");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cur[i] = 0;
    #1 chk_reset("rst_release");

    // Long run: 25 up counts by 1 from 0
    wraps = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc(0, 0, 1, 1, 1);
      settle();
      if (w[0]) wraps++;
      chk($sformatf("long_tc_up_%0d", k), int'(tu[0]),
          SAT ? int'(k >= 9) : int'(k == 9 || k == 19));
    end
    chk("long_out", int'(o[0]), SAT ? 9 : 5);
    chk("long_wraps", wraps, SAT ? 16 : 2);
    chk("long_out_m99", int'(o[2]), 25);

    // Drain the scoreboard within a bounded wait
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter: configurable width, modulus and step size, with synchronous load, count enable, terminal-count flags and a wrap-event pulse. It is the general-purpose successor to the fixed 8-bit up/down counter and serves as the counting primitive for address generators, timers and credit trackers. Optional saturation replaces modular wrap at build time.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `MAX_VAL`, 2**WIDTH-1: highest count value; modulus is MAX_VAL+1; legal range 1..2**WIDTH-1.
- `STEP_W`, 4: width of the step input; legal range 1..WIDTH.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `up_down`  in  1  direction: 1 = up, 0 = down.
- `step`  in  STEP_W  increment/decrement magnitude; 0 = hold.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `out`  out  WIDTH  current count.
- `tc_up`  out  1  high while out == MAX_VAL.
- `tc_dn`  out  1  high while out == 0.
- `wrap`  out  1  one-cycle pulse; the update that produced the current out crossed the MAX_VAL/0 boundary.

## Operation
- Reset (rst low, asynchronous): out = 0, wrap = 0, tc_dn = 1, tc_up = 0. All outputs hold these values until the first rising clk edge after rst deasserts.
- Priority per edge: load > en > hold.
- Load: out <= min(load_val, MAX_VAL); wrap <= 0. Out-of-range load values clamp to MAX_VAL.
- Count up (en = 1, up_down = 1):
  - If out + step <= MAX_VAL: out <= out + step, wrap <= 0.
  - Otherwise: out <= out + step - (MAX_VAL+1), wrap <= 1.
- Count down (en = 1, up_down = 0):
  - If step <= out: out <= out - step, wrap <= 0.
  - Otherwise: out <= out + (MAX_VAL+1) - step, wrap <= 1.
- Steps larger than MAX_VAL+1 are reduced modulo MAX_VAL+1 before use; the wrap rule applies to the reduced step.
- Internal arithmetic uses WIDTH+1 bits so that no intermediate sum overflows.
- Hold (en = 0, or step == 0 with en = 1): out unchanged, wrap <= 0.
- tc_up and tc_dn decode from the out register, so they always match out.
- Simultaneous load and en: load wins and the count is discarded.
- Reset asserted mid-count: state returns to reset values immediately, regardless of clk.

## Timing
- Single-cycle latency: inputs sampled at edge N appear on out at edge N (registered), visible in cycle N+1.
- wrap is registered alongside out and lasts exactly one cycle unless the next update wraps again.
- tc_up and tc_dn change in the same cycle as out.
- No combinational path from any input to any output.

## Configuration
- `UDC_SATURATE_EN` defined:
  - Counting up clamps at MAX_VAL.
  - Counting down clamps at 0.
  - wrap pulses when a clamp occurred, including an attempt to count past an endpoint that out already sits on.
- `UDC_SATURATE_EN` undefined: modular wrap as described in Operation.
- Load behaviour and flag behaviour are identical in both builds.

## Test plan
- Reset: rst low mid-count at out = 0x37 -> out = 0, tc_dn = 1, tc_up = 0, wrap = 0 before the next clk edge.
- Wrap up (WIDTH = 8, MAX_VAL = 9, step = 3): load 8, one up count -> out = 1, wrap = 1 for one cycle. Saturate build -> out = 9, wrap = 1.
- Wrap down (MAX_VAL = 255, step = 5): load 2, one down count -> out = 253, wrap = 1. Saturate build -> out = 0, wrap = 1.
- Priority: load = 1, load_val = 0x40, en = 1, up_down = 1, step = 1 -> out = 0x40, wrap = 0. Load of 0xFF with MAX_VAL = 99 -> out = 99, tc_up = 1.
- Hold: en = 1, step = 0 for 4 cycles at out = 5 -> out stays 5, wrap = 0. en = 0 with step = 7 -> out unchanged.
- Long run: MAX_VAL = 9, step = 1, 25 up counts from 0 -> out = 5, exactly 2 wrap pulses, tc_up high on counts 9 and 19.
